ws2812b_encoder: RTL

WS2812B single-wire transmitter for the TinyQV byte peripheral domain, running at the 64 MHz project clock. It accepts 24-bit GRB pixels over a valid/ready handshake and serialises them MSB-first as NRZ high/low pulse pairs on `dout`. It chains pixels back-to-back without gaps and closes each frame with a low latch (reset) period. It is the transmit-side counterpart of the WS2812B pulse decoder / byte assembler chain, and drives an LED strip or a downstream decoder from a `uo_out` pin.

---
 rtl/ws2812b_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ws2812b_encoder.sv
// WS2812B single-wire transmitter: 24-bit GRB pixels in over valid/ready, NRZ pulse pairs out on dout.
// Optional global brightness scaling at load is enabled by defining WS2812B_ENC_BRIGHTNESS_EN.
module ws2812b_encoder #(
  parameter int CLK_HZ       = 64000000,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int TBIT_CYCLES  = 80,
  parameter int RESET_CYCLES = 3840
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [23:0] pixel_grb,
`ifdef WS2812B_ENC_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic        pixel_ready,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(TBIT_CYCLES);
  localparam int LW = $clog2(RESET_CYCLES);

  if (CLK_HZ <= 0 || T0H_CYCLES <= 0 || T1H_CYCLES <= T0H_CYCLES ||
      TBIT_CYCLES <= T1H_CYCLES || RESET_CYCLES <= 1) begin : g_bad_params
    $error("ws2812b_encoder: illegal timing parameters");
  end

  // Handshake: a pixel transfers on any edge where pixel_valid && pixel_ready;
  // pixel_ready never depends on pixel_valid and the producer holds data until then.
  typedef enum logic [1:0] {S_IDLE, S_BIT, S_LATCH} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [4:0]  bit_idx, bit_idx_n;
  logic [23:0] shreg, shreg_n;
  logic        dout_n, done_n;
  logic        accept, last_cycle;
  logic [23:0] load_val;

`ifdef WS2812B_ENC_BRIGHTNESS_EN
  logic [8:0]  scale;
  logic [15:0] prod_g, prod_r, prod_b;

  assign scale  = {1'b0, brightness} + 9'd1;
  assign prod_g = {8'd0, pixel_grb[23:16]} * {7'd0, scale};
  assign prod_r = {8'd0, pixel_grb[15:8]}  * {7'd0, scale};
  assign prod_b = {8'd0, pixel_grb[7:0]}   * {7'd0, scale};
  assign load_val = {8'(prod_g >> 8), 8'(prod_r >> 8), 8'(prod_b >> 8)};
`else
  assign load_val = pixel_grb;
`endif

  assign last_cycle  = (cnt == CW'(TBIT_CYCLES - 1));
  assign pixel_ready = (state == S_IDLE) ||
                       (state == S_BIT && bit_idx == 5'd23 && last_cycle);
  assign accept      = pixel_valid && pixel_ready;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lcnt_n    = lcnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_BIT;
          shreg_n   = load_val;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      S_BIT: begin
        if (!last_cycle) begin
          cnt_n = cnt + CW'(1);
        end else if (bit_idx != 5'd23) begin
          shreg_n   = {shreg[22:0], 1'b0};
          cnt_n     = '0;
          bit_idx_n = bit_idx + 5'd1;
        end else if (accept) begin
          // Back-to-back pixel: reload without any low gap.
          shreg_n   = load_val;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          state_n = S_LATCH;
          lcnt_n  = '0;
        end
      end
      S_LATCH: begin
        if (lcnt == LW'(RESET_CYCLES - 1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // dout is registered, so it is derived from the state the next cycle will hold.
    dout_n = (state_n == S_BIT) &&
             (cnt_n < (shreg_n[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      lcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      dout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lcnt    <= lcnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      dout    <= dout_n;
      done    <= done_n;
    end
  end

endmodule
